mem_lsu_ctrl: RTL and testbench
===============================

// Module: mem_lsu_ctrl
// PURPOSE
//  Load/store unit between the execute stage and the data port of the dual-port simulation memory.
//  Accepts one load/store request at a time over valid/ready and drives the memory data port.
//  Derives the write byte masks from the access size; store data and addresses are LSB-aligned and byte-granular.
//  Size-extracts and sign/zero-extends load data, then returns it over a valid/ready response channel.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width
//  DATA_WIDTH  32  data width; the implementation supports only 32
// PORTS
//  clock                 in   1           single clock, rising edge
//  reset                 in   1           asynchronous, active-high
//  pLsu_pReq_bValid      in   1           request valid
//  pLsu_pReq_bReady      out  1           request ready
//  pLsu_pReq_bWrEn       in   1           1 = store, 0 = load
//  pLsu_pReq_bSize       in   2           0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
//  pLsu_pReq_bUnsigned   in   1           load zero-extend when 1, sign-extend when 0
//  pLsu_pReq_bAddr       in   ADDR_WIDTH  byte address
//  pLsu_pReq_bData       in   DATA_WIDTH  store data, LSB-aligned
//  pLsu_pResp_bValid     out  1           response valid
//  pLsu_pResp_bReady     in   1           response ready
//  pLsu_pResp_bData      out  DATA_WIDTH  extended load data; 0 for stores
//  pLsu_pResp_bMisalign  out  1           misaligned access flag
//  pMemData_pRd_bEn      out  1           memory read enable
//  pMemData_pRd_bAddr    out  ADDR_WIDTH  memory read address
//  pMemData_pRd_bData    in   DATA_WIDTH  memory read data; combinational on address
//  pMemData_pWr_bEn      out  1           memory write enable
//  pMemData_pWr_bAddr    out  ADDR_WIDTH  memory write address
//  pMemData_pWr_bData    out  DATA_WIDTH  memory write data
//  pMemData_pWr_bMask_0..3  out  1 each   byte-lane enables; _3 = lane 0 (lowest byte), _0 = lane 3
// BEHAVIOUR
//  Reset values:
//    - FSM goes to IDLE.
//    - ReqReady = 0 while reset is asserted.
//    - RespValid = 0, RespData = 0, Misalign = 0.
//    - Both memory enables = 0 and all masks = 0.
//    - Both memory addresses = all-ones; WrData = 0.
//  FSM states IDLE -> ACCESS -> RESP -> IDLE:
//    - IDLE: ReqReady = 1. On Valid & Ready, latch WrEn, Size, Unsigned, Addr and Data, then go to ACCESS.
//    - ACCESS (exactly 1 cycle):
//      - Drive the latched address on both memory address ports.
//      - Load: RdEn = 1; register the extracted result from RdData at the cycle's end.
//      - Store: WrEn = 1 for this cycle only; WrData = latched data.
//      - Go to RESP.
//    - RESP: RespValid = 1; RespData and Misalign are held stable until RespReady. On handshake go to IDLE.
//  Outside ACCESS: memory enables = 0, masks = 0, both addresses = all-ones.
//    - This guarantees an address change at every access, which the memory model requires.
//    - Byte accesses to address 0xFFFF_FFFF are therefore unsupported.
//  Latency and throughput:
//    - Request accepted at edge N gives RespValid from cycle N+2 (RespReady held high).
//    - One transaction at a time; ReqReady = 0 in ACCESS and RESP.
//  Write mask {_0,_1,_2,_3}: byte = 0001, half = 0011, word/reserved = 1111.
//  Load extraction from RdData (memory returns LSB-aligned bytes at Addr):
//    - byte: [7:0]; half: [15:0]; word: [31:0].
//    - Sign bit is replicated unless Unsigned = 1.
//  RespValid held with RespReady = 0 stalls the block in RESP indefinitely; requests are not accepted meanwhile.
//  Reset mid-operation takes effect immediately:
//    - An in-flight write's WrEn drops immediately; memory side effects of that write are unspecified.
//    - A pending response is discarded.
// CONFIGURATION
//  MEM_LSU_MISALIGN_CHECK_EN defined:
//    - Half with Addr[0] = 1, or word/reserved with Addr[1:0] != 0, is misaligned.
//    - For a misaligned access, ACCESS asserts no memory enable and RESP returns Misalign = 1, RespData = 0.
//  MEM_LSU_MISALIGN_CHECK_EN undefined:
//    - Misalign is tied to 0.
//    - Every access proceeds to memory unchanged.
// TESTING
//  - Word store 0xDEADBEEF @0x80000100, then word load @0x80000100 -> WrEn pulses 1 cycle with mask 1111; load RespData = 0xDEADBEEF at N+2.
//  - Memory byte @0x80000103 = 0x80; LB then LBU @0x80000103 -> RespData 0xFFFFFF80, then 0x00000080.
//  - SH data 0x1234ABCD @0x80000202 -> mask 0011, WrData 0x1234ABCD; subsequent LH returns 0xFFFFABCD.
//  - Hold RespReady = 0 for 5 cycles after a load -> RespValid and RespData stable, ReqReady = 0; completes on the first RespReady.
//  - Two back-to-back loads from the same address -> two RdEn pulses; addresses return to all-ones between them.
//  - Assert reset in ACCESS of a store -> WrEn = 0 and RespValid = 0 immediately; ReqReady = 1 on the first cycle after release.
//  - With MEM_LSU_MISALIGN_CHECK_EN, LW @0x80000001 -> no RdEn; RespValid with Misalign = 1 and RespData = 0.

Source files
------------

// File: rtl/mem_lsu_ctrl_if.sv
// Bus bundle for mem_lsu_ctrl: request/response channel from execute and the memory data port.
// slave = the LSU; master = the surrounding execute stage plus memory.
interface mem_lsu_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  pLsu_pReq_bValid;
  logic                  pLsu_pReq_bReady;
  logic                  pLsu_pReq_bWrEn;
  logic [1:0]            pLsu_pReq_bSize;
  logic                  pLsu_pReq_bUnsigned;
  logic [ADDR_WIDTH-1:0] pLsu_pReq_bAddr;
  logic [DATA_WIDTH-1:0] pLsu_pReq_bData;
  logic                  pLsu_pResp_bValid;
  logic                  pLsu_pResp_bReady;
  logic [DATA_WIDTH-1:0] pLsu_pResp_bData;
  logic                  pLsu_pResp_bMisalign;
  logic                  pMemData_pRd_bEn;
  logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr;
  logic [DATA_WIDTH-1:0] pMemData_pRd_bData;
  logic                  pMemData_pWr_bEn;
  logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr;
  logic [DATA_WIDTH-1:0] pMemData_pWr_bData;
  logic                  pMemData_pWr_bMask_0;
  logic                  pMemData_pWr_bMask_1;
  logic                  pMemData_pWr_bMask_2;
  logic                  pMemData_pWr_bMask_3;

  modport slave (
    input  pLsu_pReq_bValid, pLsu_pReq_bWrEn, pLsu_pReq_bSize, pLsu_pReq_bUnsigned,
           pLsu_pReq_bAddr, pLsu_pReq_bData, pLsu_pResp_bReady, pMemData_pRd_bData,
    output pLsu_pReq_bReady, pLsu_pResp_bValid, pLsu_pResp_bData, pLsu_pResp_bMisalign,
           pMemData_pRd_bEn, pMemData_pRd_bAddr, pMemData_pWr_bEn, pMemData_pWr_bAddr,
           pMemData_pWr_bData, pMemData_pWr_bMask_0, pMemData_pWr_bMask_1,
           pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
  );

  modport master (
    output pLsu_pReq_bValid, pLsu_pReq_bWrEn, pLsu_pReq_bSize, pLsu_pReq_bUnsigned,
           pLsu_pReq_bAddr, pLsu_pReq_bData, pLsu_pResp_bReady, pMemData_pRd_bData,
    input  pLsu_pReq_bReady, pLsu_pResp_bValid, pLsu_pResp_bData, pLsu_pResp_bMisalign,
           pMemData_pRd_bEn, pMemData_pRd_bAddr, pMemData_pWr_bEn, pMemData_pWr_bAddr,
           pMemData_pWr_bData, pMemData_pWr_bMask_0, pMemData_pWr_bMask_1,
           pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
  );
endinterface

// File: rtl/mem_lsu_ctrl.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP, byte masks and load extension.
// Define MEM_LSU_MISALIGN_CHECK_EN to flag and suppress misaligned half/word accesses.
module mem_lsu_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  mem_lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  misalign_q, misalign_d;

  logic                  misaligned;
  logic [3:0]            lane_mask;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  sign_bit;

  always_comb begin
`ifdef MEM_LSU_MISALIGN_CHECK_EN
    case (size_q)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_q[0];
      default: misaligned = |addr_q[1:0];
    endcase
`else
    misaligned = 1'b0;
`endif
  end

  // lane_mask[i] enables byte lane i; lane 0 is the lowest byte.
  always_comb begin
    case (size_q)
      2'd0:    lane_mask = 4'b0001;
      2'd1:    lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  always_comb begin
    sign_bit = 1'b0;
    load_ext = bus.pMemData_pRd_bData;
    case (size_q)
      2'd0: begin
        sign_bit = ~uns_q & bus.pMemData_pRd_bData[7];
        load_ext = {{(DATA_WIDTH-8){sign_bit}}, bus.pMemData_pRd_bData[7:0]};
      end
      2'd1: begin
        sign_bit = ~uns_q & bus.pMemData_pRd_bData[15];
        load_ext = {{(DATA_WIDTH-16){sign_bit}}, bus.pMemData_pRd_bData[15:0]};
      end
      default: load_ext = bus.pMemData_pRd_bData;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_data_d = resp_data_q;
    misalign_d  = misalign_q;

    bus.pLsu_pReq_bReady   = 1'b0;
    bus.pLsu_pResp_bValid  = 1'b0;
    bus.pMemData_pRd_bEn   = 1'b0;
    bus.pMemData_pWr_bEn   = 1'b0;
    bus.pMemData_pRd_bAddr = '1;
    bus.pMemData_pWr_bAddr = '1;
    bus.pMemData_pWr_bData = '0;
    {bus.pMemData_pWr_bMask_0, bus.pMemData_pWr_bMask_1,
     bus.pMemData_pWr_bMask_2, bus.pMemData_pWr_bMask_3} = 4'b0000;

    case (state_q)
      S_IDLE: begin
        bus.pLsu_pReq_bReady = ~reset;
        if (bus.pLsu_pReq_bValid && !reset) begin
          we_d    = bus.pLsu_pReq_bWrEn;
          size_d  = bus.pLsu_pReq_bSize;
          uns_d   = bus.pLsu_pReq_bUnsigned;
          addr_d  = bus.pLsu_pReq_bAddr;
          data_d  = bus.pLsu_pReq_bData;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Addresses leave all-ones only here, so every access presents a fresh address.
        bus.pMemData_pRd_bAddr = addr_q;
        bus.pMemData_pWr_bAddr = addr_q;
        if (!misaligned) begin
          if (we_q) begin
            bus.pMemData_pWr_bEn   = 1'b1;
            bus.pMemData_pWr_bData = data_q;
            {bus.pMemData_pWr_bMask_0, bus.pMemData_pWr_bMask_1,
             bus.pMemData_pWr_bMask_2, bus.pMemData_pWr_bMask_3} = lane_mask;
          end else begin
            bus.pMemData_pRd_bEn = 1'b1;
          end
        end
        resp_data_d = (we_q || misaligned) ? '0 : load_ext;
        misalign_d  = misaligned;
        state_d     = S_RESP;
      end
      S_RESP: begin
        bus.pLsu_pResp_bValid = 1'b1;
        if (bus.pLsu_pResp_bReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.pLsu_pResp_bData     = resp_data_q;
  assign bus.pLsu_pResp_bMisalign = misalign_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_data_q <= resp_data_d;
      misalign_q  <= misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed bench for mem_lsu_ctrl with a byte-array memory model and a response scoreboard.
module tb_mem_lsu_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  mem_lsu_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [4096];
  logic [11:0] ra, wa;
  logic [3:0]  wlane;
  assign ra    = bus.pMemData_pRd_bAddr[11:0];
  assign wa    = bus.pMemData_pWr_bAddr[11:0];
  assign wlane = {bus.pMemData_pWr_bMask_0, bus.pMemData_pWr_bMask_1,
                  bus.pMemData_pWr_bMask_2, bus.pMemData_pWr_bMask_3};

  always_comb begin
    bus.pMemData_pRd_bData = {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]};
  end

  always @(posedge clk) begin
    if (bus.pMemData_pWr_bEn) begin
      for (int i = 0; i < 4; i++)
        if (wlane[i]) mem[wa + 12'(i)] <= bus.pMemData_pWr_bData[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mask_for(input logic [1:0] sz);
    if (sz == 2'd0)      return 4'b0001;
    else if (sz == 2'd1) return 4'b0011;
    else                 return 4'b1111;
  endfunction

  // Issues one request (entered ~#1 after a rising edge, DUT in IDLE) and checks every phase.
  task automatic lsu_op(input string tag, input logic we, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_mis,
                        input int unsigned stall);
    exp_t e;
    logic go;
    chk({tag, ":idle_rdy"}, 32'(bus.pLsu_pReq_bReady), 32'd1);
    chk({tag, ":idle_raddr"}, bus.pMemData_pRd_bAddr, 32'hFFFF_FFFF);
    bus.pLsu_pReq_bValid    = 1'b1;
    bus.pLsu_pReq_bWrEn     = we;
    bus.pLsu_pReq_bSize     = sz;
    bus.pLsu_pReq_bUnsigned = un;
    bus.pLsu_pReq_bAddr     = a;
    bus.pLsu_pReq_bData     = d;
    sb.push_back('{data: exp_data, mis: exp_mis});
    @(posedge clk); #1;
    bus.pLsu_pReq_bValid = 1'b0;
    go = !exp_mis;
    chk({tag, ":acc_rdy"}, 32'(bus.pLsu_pReq_bReady), 32'd0);
    chk({tag, ":acc_rvalid"}, 32'(bus.pLsu_pResp_bValid), 32'd0);
    chk({tag, ":acc_raddr"}, bus.pMemData_pRd_bAddr, a);
    chk({tag, ":acc_waddr"}, bus.pMemData_pWr_bAddr, a);
    chk({tag, ":acc_rden"}, 32'(bus.pMemData_pRd_bEn), 32'(!we && go));
    chk({tag, ":acc_wren"}, 32'(bus.pMemData_pWr_bEn), 32'(we && go));
    chk({tag, ":acc_mask"}, 32'(wlane), (we && go) ? 32'(mask_for(sz)) : 32'd0);
    if (we && go) chk({tag, ":acc_wdata"}, bus.pMemData_pWr_bData, d);
    bus.pLsu_pResp_bReady = (stall == 0);
    @(posedge clk); #1;
    for (int unsigned i = 0; i < stall; i++) begin
      chk({tag, ":stall_valid"}, 32'(bus.pLsu_pResp_bValid), 32'd1);
      chk({tag, ":stall_rdy"}, 32'(bus.pLsu_pReq_bReady), 32'd0);
      chk({tag, ":stall_data"}, bus.pLsu_pResp_bData, sb[0].data);
      @(posedge clk); #1;
    end
    bus.pLsu_pResp_bReady = 1'b1;
    chk({tag, ":resp_valid"}, 32'(bus.pLsu_pResp_bValid), 32'd1);
    chk({tag, ":resp_wren"}, 32'(bus.pMemData_pWr_bEn), 32'd0);
    chk({tag, ":resp_rden"}, 32'(bus.pMemData_pRd_bEn), 32'd0);
    chk({tag, ":resp_waddr"}, bus.pMemData_pWr_bAddr, 32'hFFFF_FFFF);
    chk({tag, ":resp_rdy"}, 32'(bus.pLsu_pReq_bReady), 32'd0);
    if (bus.pLsu_pResp_bValid && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ":resp_data"}, bus.pLsu_pResp_bData, e.data);
      chk({tag, ":resp_mis"}, 32'(bus.pLsu_pResp_bMisalign), 32'(e.mis));
    end
    @(posedge clk); #1;
    chk({tag, ":done_valid"}, 32'(bus.pLsu_pResp_bValid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.pLsu_pReq_bValid    = 1'b0;
    bus.pLsu_pReq_bWrEn     = 1'b0;
    bus.pLsu_pReq_bSize     = 2'd0;
    bus.pLsu_pReq_bUnsigned = 1'b0;
    bus.pLsu_pReq_bAddr     = '0;
    bus.pLsu_pReq_bData     = '0;
    bus.pLsu_pResp_bReady   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:req_rdy", 32'(bus.pLsu_pReq_bReady), 32'd0);
    chk("rst:resp_valid", 32'(bus.pLsu_pResp_bValid), 32'd0);
    chk("rst:resp_data", bus.pLsu_pResp_bData, 32'd0);
    chk("rst:mis", 32'(bus.pLsu_pResp_bMisalign), 32'd0);
    chk("rst:rden", 32'(bus.pMemData_pRd_bEn), 32'd0);
    chk("rst:wren", 32'(bus.pMemData_pWr_bEn), 32'd0);
    chk("rst:mask", 32'(wlane), 32'd0);
    chk("rst:raddr", bus.pMemData_pRd_bAddr, 32'hFFFF_FFFF);
    chk("rst:waddr", bus.pMemData_pWr_bAddr, 32'hFFFF_FFFF);
    chk("rst:wdata", bus.pMemData_pWr_bData, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    lsu_op("sw",   1'b1, 2'd2, 1'b0, 32'h8000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0);
    lsu_op("lw",   1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
    lsu_op("sb",   1'b1, 2'd0, 1'b0, 32'h8000_0103, 32'h0000_0080, 32'h0000_0000, 1'b0, 0);
    lsu_op("lb",   1'b0, 2'd0, 1'b0, 32'h8000_0103, 32'h0,         32'hFFFF_FF80, 1'b0, 0);
    lsu_op("lbu",  1'b0, 2'd0, 1'b1, 32'h8000_0103, 32'h0,         32'h0000_0080, 1'b0, 0);
    lsu_op("sh",   1'b1, 2'd1, 1'b0, 32'h8000_0202, 32'h1234_ABCD, 32'h0000_0000, 1'b0, 0);
    lsu_op("lh",   1'b0, 2'd1, 1'b0, 32'h8000_0202, 32'h0,         32'hFFFF_ABCD, 1'b0, 0);
    lsu_op("lhu",  1'b0, 2'd1, 1'b1, 32'h8000_0202, 32'h0,         32'h0000_ABCD, 1'b0, 0);
    lsu_op("lrsv", 1'b0, 2'd3, 1'b0, 32'h8000_0100, 32'h0,         32'h80AD_BEEF, 1'b0, 0);
    lsu_op("stall",1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'h0,         32'h80AD_BEEF, 1'b0, 5);
    lsu_op("b2b0", 1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'h0,         32'h80AD_BEEF, 1'b0, 0);
    lsu_op("b2b1", 1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'h0,         32'h80AD_BEEF, 1'b0, 0);
`ifdef MEM_LSU_MISALIGN_CHECK_EN
    lsu_op("lh_odd", 1'b0, 2'd1, 1'b0, 32'h8000_0101, 32'h0, 32'h0000_0000, 1'b1, 0);
    lsu_op("lw_mis", 1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0, 32'h0000_0000, 1'b1, 0);
    lsu_op("sw_mis", 1'b1, 2'd2, 1'b0, 32'h8000_0102, 32'h5555_5555, 32'h0000_0000, 1'b1, 0);
`else
    lsu_op("lh_odd", 1'b0, 2'd1, 1'b0, 32'h8000_0101, 32'h0, 32'hFFFF_ADBE, 1'b0, 0);
`endif

    // Reset during the ACCESS cycle of a store.
    bus.pLsu_pReq_bValid = 1'b1;
    bus.pLsu_pReq_bWrEn  = 1'b1;
    bus.pLsu_pReq_bSize  = 2'd2;
    bus.pLsu_pReq_bAddr  = 32'h8000_0300;
    bus.pLsu_pReq_bData  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.pLsu_pReq_bValid = 1'b0;
    chk("rstmid:wren_pre", 32'(bus.pMemData_pWr_bEn), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid:wren", 32'(bus.pMemData_pWr_bEn), 32'd0);
    chk("rstmid:resp_valid", 32'(bus.pLsu_pResp_bValid), 32'd0);
    chk("rstmid:req_rdy", 32'(bus.pLsu_pReq_bReady), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstmid:rdy_after", 32'(bus.pLsu_pReq_bReady), 32'd1);
    chk("rstmid:resp_after", 32'(bus.pLsu_pResp_bValid), 32'd0);
    @(posedge clk); #1;
    chk("rstmid:resp_idle", 32'(bus.pLsu_pResp_bValid), 32'd0);

    lsu_op("post", 1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'h0, 32'h80AD_BEEF, 1'b0, 0);
    chk("sb:empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
